// File: rtl/div_ctrl.sv
// div_ctrl: sequencer between the EX stage and the iterative 32-bit divider.
// Turns a DIV/DIVU in EX into a start/annul handshake, stalls EX while the
// divider runs, returns {rem,quot} for HI/LO writeback, cancels on flush and
// recovers through a watchdog when the divider never answers.
//
// Handshake with the divider: div_start_o is held high for the whole time the
// divider is expected to work (BUSY) and dropped once the result has been
// captured (DONE) or the operation is abandoned (CANCEL). div_ready_i is only
// honoured while div_start_o is high. After an abort div_annul_o is held
// high with div_start_o low for CANCEL_CYCLES cycles so the divider is idle
// again before the next request can start it.
module div_ctrl #(
  parameter int CANCEL_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        req_signed_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        flush_i,
  input  logic        pipe_hold_i,
  output logic        stall_req_o,
  output logic [63:0] result_o,
  output logic        result_valid_o,
  output logic        div_by_zero_o,
  output logic        timeout_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic [1:0]  dbg_state_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [1:0] S_CANCEL = 2'd3;

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CC_W = $clog2(CANCEL_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CC_W-1:0] CC_LAST = CC_W'(CANCEL_CYCLES - 1);

  logic [1:0]      state;
  logic [WD_W-1:0] wd_cnt;
  logic [CC_W-1:0] cc_cnt;
  logic [31:0]     op1_q;
  logic [31:0]     op2_q;
  logic            signed_q;
  logic            dz_q;
  logic [63:0]     result_q;
  logic            timeout_q;

  // Sequencer state, operand latch, result capture, watchdog and cancel timer
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wd_cnt    <= '0;
      cc_cnt    <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      signed_q  <= 1'b0;
      dz_q      <= 1'b0;
      result_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_i && !flush_i) begin
            // Operands stay frozen until the next accepted request; the
            // divider's sign fix-up relies on them not moving.
            op1_q    <= op1_i;
            op2_q    <= op2_i;
            signed_q <= req_signed_i;
            dz_q     <= (op2_i == 32'd0);
            wd_cnt   <= '0;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Flush beats a same-cycle ready and the watchdog.
          if (flush_i) begin
            cc_cnt <= '0;
            state  <= S_CANCEL;
          end else if (div_ready_i) begin
            result_q <= dz_q ? 64'd0 : div_result_i;
            state    <= S_DONE;
          end else if (wd_cnt == WD_LAST) begin
            timeout_q <= 1'b1;
            cc_cnt    <= '0;
            state     <= S_CANCEL;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        S_DONE: begin
          if (flush_i || !pipe_hold_i) begin
            state <= S_IDLE;
          end
        end
        S_CANCEL: begin
          if (cc_cnt == CC_LAST) begin
            state <= S_IDLE;
          end else begin
            cc_cnt <= cc_cnt + CC_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode from the current state; the request-cycle stall is combinational
  always_comb begin
    stall_req_o    = (state == S_BUSY) || ((state == S_IDLE) && req_i && !flush_i);
    div_start_o    = (state == S_BUSY);
    div_annul_o    = (state == S_CANCEL);
    result_valid_o = (state == S_DONE) && !flush_i;
    div_by_zero_o  = (state == S_DONE) && !flush_i && dz_q;
  end

  assign result_o      = result_q;
  assign timeout_o     = timeout_q;
  assign div_signed_o  = signed_q;
  assign div_opdata1_o = op1_q;
  assign div_opdata2_o = op2_q;
  assign dbg_state_o   = state;

endmodule
